cd_tx_frame_reader: RTL

- Consumer side of the ping-pong frame buffer.
- When the buffer reports an unread frame, this block reads it out byte by byte and streams it to the tx serializer over a valid/ready handshake.
- On completion it releases the slot with a one-cycle rd_done pulse.
- Frame layout: hdr[0]=src, hdr[1]=dst, hdr[2]=len, then len data bytes; total = 3 + len bytes.

---
 rtl/cd_pkg.sv | 18 +
 rtl/cd_tx_frame_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared frame-buffer constants and tx frame reader state encoding
package cd_pkg;

   // Frame header: hdr[0]=src, hdr[1]=dst, hdr[2]=len, followed by len data bytes
   localparam int CD_HDR_LEN = 3;
   localparam int CD_LEN_IDX = 2;

   typedef enum logic [2:0] {
      CD_IDLE  = 3'd0,
      CD_LEN_A = 3'd1,
      CD_LEN_D = 3'd2,
      CD_RD_A  = 3'd3,
      CD_RD_D  = 3'd4,
      CD_SEND  = 3'd5,
      CD_DONE  = 3'd6
   } cd_tx_state_e;

endpackage

// File: rtl/cd_tx_frame_reader.sv
// rtl/cd_tx_frame_reader.sv - frame buffer consumer streaming frames to the tx serializer (option: CD_TX_RETRY_LIMIT_EN)
module cd_tx_frame_reader
   import cd_pkg::*;
#(
   parameter int A_WIDTH   = 8,
   parameter int RETRY_MAX = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         rd_byte,
   input  logic [7:0]         rd_flags,
   input  logic               unread,
   output logic [A_WIDTH-1:0] rd_addr,
   output logic               rd_done,
   output logic [7:0]         tx_byte,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               tx_first,
   output logic               tx_last,
   output logic [7:0]         tx_flags,
   input  logic               abort,
   input  logic               flush,
   output logic               busy,
   output logic               len_err,
   output logic               retry_drop
);

   // Length sum is evaluated wide enough to hold 3+255 and the slot size itself
   localparam int SUM_W = (A_WIDTH + 2 > 10) ? A_WIDTH + 2 : 10;
   localparam logic [SUM_W-1:0]   SLOT_BYTES = SUM_W'(1) << A_WIDTH;
   localparam logic [A_WIDTH:0]   IDX_ONE    = {{A_WIDTH{1'b0}}, 1'b1};
   localparam logic [A_WIDTH-1:0] LEN_ADDR   = A_WIDTH'(CD_LEN_IDX);

   cd_tx_state_e     state;
   logic [A_WIDTH:0] idx;
   logic [A_WIDTH:0] total;
   logic [A_WIDTH:0] idx_next;
   logic [SUM_W-1:0] len_sum;
   logic             cancel;
   logic             give_up;

   assign len_sum  = SUM_W'(CD_HDR_LEN) + SUM_W'(rd_byte);
   assign idx_next = idx + IDX_ONE;
   // abort only matters while a frame is being fetched or presented
   assign cancel   = abort && (state != CD_IDLE) && (state != CD_DONE);
   assign busy     = (state != CD_IDLE);
   // release is combinational so the buffer clears unread before the next IDLE cycle
   assign rd_done  = reset_n && !flush && (state == CD_DONE);

`ifdef CD_TX_RETRY_LIMIT_EN
   localparam int RC_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RETRY_MAX - 1);

   logic [RC_W-1:0] retry_cnt;
   logic            drop_q;

   assign give_up    = cancel && (retry_cnt == RC_LAST);
   assign retry_drop = drop_q;

   // count aborted attempts of the current frame; give up after RETRY_MAX
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         retry_cnt <= '0;
         drop_q    <= 1'b0;
      end else if (cancel) begin
         drop_q    <= give_up;
         retry_cnt <= give_up ? '0 : retry_cnt + 1'b1;
      end else begin
         drop_q <= 1'b0;
         if (state == CD_DONE) begin
            retry_cnt <= '0;
         end
      end
   end
`else
   logic unused_cfg;

   assign give_up    = 1'b0;
   assign retry_drop = 1'b0;
   assign unused_cfg = (RETRY_MAX > 0);
`endif

   // frame walk: fetch length, then read / present / handshake each byte
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= CD_IDLE;
         rd_addr  <= '0;
         idx      <= '0;
         total    <= '0;
         tx_byte  <= '0;
         tx_valid <= 1'b0;
         tx_first <= 1'b0;
         tx_last  <= 1'b0;
         tx_flags <= '0;
         len_err  <= 1'b0;
      end else if (flush || cancel) begin
         // slot stays dirty on abort, so the frame restarts from byte 0
         state    <= (give_up && !flush) ? CD_DONE : CD_IDLE;
         idx      <= '0;
         tx_valid <= 1'b0;
         tx_first <= 1'b0;
         tx_last  <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         len_err <= 1'b0;
         case (state)
            CD_IDLE: begin
               if (unread) begin
                  rd_addr <= LEN_ADDR;
                  state   <= CD_LEN_A;
               end
            end
            CD_LEN_A: state <= CD_LEN_D;
            CD_LEN_D: begin
               total    <= len_sum[A_WIDTH:0];
               tx_flags <= rd_flags;
               if (len_sum > SLOT_BYTES) begin
                  len_err <= 1'b1;
                  state   <= CD_DONE;
               end else begin
                  idx     <= '0;
                  rd_addr <= '0;
                  state   <= CD_RD_A;
               end
            end
            CD_RD_A: state <= CD_RD_D;
            CD_RD_D: begin
               tx_byte  <= rd_byte;
               tx_valid <= 1'b1;
               tx_first <= (idx == '0);
               tx_last  <= (idx == total - IDX_ONE);
               state    <= CD_SEND;
            end
            CD_SEND: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if (tx_last) begin
                     state <= CD_DONE;
                  end else begin
                     idx     <= idx_next;
                     rd_addr <= idx_next[A_WIDTH-1:0];
                     state   <= CD_RD_A;
                  end
               end
            end
            CD_DONE: begin
               idx   <= '0;
               state <= CD_IDLE;
            end
            default: state <= CD_IDLE;
         endcase
      end
   end

endmodule
